// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// primary opcodes and the datapath mux select codes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_ALU_WB    = 4'd7,
      S_I_EXEC    = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_JAL       = 4'd11,
      S_JR        = 4'd12,
      S_MULT      = 4'd13
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // jr is flagged by the decoder with this flag_J_type value
   localparam logic [1:0] JTYPE_JR = 2'd2;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;
   localparam logic [1:0] M2R_LO     = 2'd3;

   localparam logic [1:0] ALUB_DEC    = 2'd0;
   localparam logic [1:0] ALUB_FOUR   = 2'd1;
   localparam logic [1:0] ALUB_OFFSET = 2'd2;

   localparam logic [1:0] ALUC_DEC = 2'd0;
   localparam logic [1:0] ALUC_ADD = 2'd1;
   localparam logic [1:0] ALUC_SUB = 2'd2;

endpackage

// File: rtl/mult_wait_counter.sv
// Counts the cycles spent in MULT and flags the last one.
module mult_wait_counter #(
   parameter int unsigned MULT_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic done
);

   localparam logic [3:0] LAST = 4'(MULT_CYCLES - 1);

   logic [3:0] cnt_q, cnt_d;

   // done on the final multiply cycle; counter rests at zero outside MULT
   always_comb begin
      done  = en && (cnt_q == LAST);
      cnt_d = (en && !done) ? cnt_q + 4'd1 : 4'd0;
   end

   // cycle counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= 4'd0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback and drives all datapath enables and mux selects.
//
// state     | meaning
// ----------+----------------------------------------------
// FETCH     | read instr at PC, PC+4, wait for mem_ready
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | base + offset for lw/sw
// MEM_READ  | data read, wait for mem_ready
// MEM_WB    | MDR to register file
// MEM_WRITE | data write, held until mem_ready
// R_EXEC    | R-type ALU operation
// ALU_WB    | ALUOut (or LO for mflo) to register file
// I_EXEC    | I-type ALU operation
// BRANCH    | beq/bne compare, conditional PC load
// JUMP      | j
// JAL       | jal, link to $31
// JR        | PC from rs
// MULT      | multi-cycle multiply, HI/LO load on last cycle
module mips_multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             flag_R_type,
   input  logic             flag_I_type,
   input  logic [1:0]       flag_J_type,
   input  logic [1:0]       flag_lw,
   input  logic             flag_sw,
   input  logic             mult_operation,
   input  logic             mflo_flag,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             IorD,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_ctrl_sel,
   output logic             reg_write,
   output logic [1:0]       mem_to_reg,
   output logic             hi_lo_write,
   output logic             illegal_instr,
   output logic [3:0]       state_dbg,
   output logic [CNT_W-1:0] retired_cnt
);

   state_e             state_q, state_d;
   logic               mflo_q, mflo_d;
   logic [CNT_W-1:0]   retired_q;
   logic               retire;
   logic               illegal;
   logic               mult_done;

   logic               mem_write_raw, ir_write_raw, pc_write_raw;
   logic               reg_write_raw, hi_lo_write_raw;

   // Dispatch uses the opcode directly; these decoder flags carry no extra information
   logic unused_flags;
   assign unused_flags = ^{flag_R_type, flag_I_type, flag_lw, flag_sw};

   mult_wait_counter #(.MULT_CYCLES(MULT_CYCLES)) u_mult_wait (
      .clk   (clk),
      .reset (reset),
      .en    (state_q == S_MULT),
      .done  (mult_done)
   );

   // next-state and dispatch logic
   always_comb begin
      state_d = state_q;
      mflo_d  = mflo_q;
      illegal = 1'b0;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            mflo_d = 1'b0;
            case (opcode)
               OP_LW, OP_SW:   state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:           state_d = S_JUMP;
               OP_JAL:         state_d = S_JAL;
               OP_RTYPE: begin
                  if (flag_J_type == JTYPE_JR) state_d = S_JR;
                  else if (mult_operation)     state_d = S_MULT;
                  else if (mflo_flag) begin
                     state_d = S_ALU_WB;
                     mflo_d  = 1'b1;
                  end
                  else                         state_d = S_R_EXEC;
               end
               OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_I_EXEC;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
         S_R_EXEC,
         S_I_EXEC:    state_d = S_ALU_WB;
         S_ALU_WB,
         S_BRANCH,
         S_JUMP,
         S_JAL,
         S_JR:        state_d = S_FETCH;
         S_MULT:      if (mult_done) state_d = S_FETCH;
         default:     state_d = S_FETCH;
      endcase
      // illegal exits from DECODE, so it is never counted here
      retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_DECODE);
   end

   // state, mflo tag and retired-instruction counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         mflo_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         mflo_q  <= mflo_d;
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   // Moore output decode; only mem_ready, alu_zero and the MULT done gate strobes
   always_comb begin
      IorD            = 1'b0;
      mem_read        = 1'b0;
      mem_write_raw   = 1'b0;
      ir_write_raw    = 1'b0;
      pc_write_raw    = 1'b0;
      pc_src          = PC_SRC_ALU;
      alu_src_a       = 1'b0;
      alu_src_b       = ALUB_DEC;
      alu_ctrl_sel    = ALUC_DEC;
      reg_write_raw   = 1'b0;
      mem_to_reg      = M2R_ALUOUT;
      hi_lo_write_raw = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read     = 1'b1;
            alu_src_b    = ALUB_FOUR;
            alu_ctrl_sel = ALUC_ADD;
            ir_write_raw = mem_ready;
            pc_write_raw = mem_ready;
         end
         S_DECODE: begin
            alu_src_b    = ALUB_OFFSET;
            alu_ctrl_sel = ALUC_ADD;
         end
         S_MEM_ADDR: begin
            alu_src_a    = 1'b1;
            alu_src_b    = ALUB_OFFSET;
            alu_ctrl_sel = ALUC_ADD;
         end
         S_MEM_READ: begin
            IorD     = 1'b1;
            mem_read = 1'b1;
         end
         S_MEM_WB: begin
            reg_write_raw = 1'b1;
            mem_to_reg    = M2R_MDR;
         end
         S_MEM_WRITE: begin
            IorD          = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_R_EXEC,
         S_I_EXEC:    alu_src_a = 1'b1;
         S_ALU_WB: begin
            reg_write_raw = 1'b1;
            mem_to_reg    = mflo_q ? M2R_LO : M2R_ALUOUT;
         end
         S_BRANCH: begin
            alu_src_a    = 1'b1;
            alu_ctrl_sel = ALUC_SUB;
            pc_src       = PC_SRC_ALUOUT;
            pc_write_raw = (opcode == OP_BNE) ? !alu_zero : alu_zero;
         end
         S_JUMP: begin
            pc_write_raw = 1'b1;
            pc_src       = PC_SRC_JUMP;
         end
         S_JAL: begin
            reg_write_raw = 1'b1;
            mem_to_reg    = M2R_PC;
            pc_write_raw  = 1'b1;
            pc_src        = PC_SRC_JUMP;
         end
         S_JR: begin
            pc_write_raw = 1'b1;
            pc_src       = PC_SRC_RS;
         end
         S_MULT: begin
            alu_src_a       = 1'b1;
            hi_lo_write_raw = mult_done;
         end
         default: ;
      endcase
   end

   // strobes are forced low while reset is held so no partial write escapes
   assign mem_write     = reset & mem_write_raw;
   assign ir_write      = reset & ir_write_raw;
   assign pc_write      = reset & pc_write_raw;
   assign reg_write     = reset & reg_write_raw;
   assign hi_lo_write   = reset & hi_lo_write_raw;
   assign illegal_instr = reset & illegal;
   assign state_dbg     = state_q;
   assign retired_cnt   = retired_q;

endmodule
